// File: rtl/audio_source_arbiter.sv
// audio_source_arbiter
// Two-source frame arbiter in front of the I2S sample FIFO write port.
// Source 0 is the sine generator, source 1 the processor sample stream.
// Whole stereo frames are granted by fixed priority or round-robin, the
// winner is captured in a single output register, and accepted frames are
// counted per source for software status.
module audio_source_arbiter #(
  parameter int BW = 48,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    cfg_src_en,
  input  logic          cfg_rr,
  input  logic          cfg_clr_cnt,
  input  logic [BW-1:0] s0_data,
  input  logic          s0_valid,
  output logic          s0_ready,
  input  logic [BW-1:0] s1_data,
  input  logic          s1_valid,
  output logic          s1_ready,
  output logic [BW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          grant,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1
);

  // Registered state: output stage, last granted source, frame counters.
  logic [BW-1:0] r_m_data;
  logic          r_m_valid;
  logic          r_grant;
  logic          r_last;
  logic [CW-1:0] r_cnt0;
  logic [CW-1:0] r_cnt1;

  // Combinational arbitration signals.
  logic w_elig0;
  logic w_elig1;
  logic w_free;
  logic w_winner;
  logic w_acc0;
  logic w_acc1;
  logic w_acc;

  assign w_elig0 = s0_valid & cfg_src_en[0];
  assign w_elig1 = s1_valid & cfg_src_en[1];

  // The output slot can take a new frame when empty or when it drains
  // this same cycle, which gives one frame per cycle under full flow.
  assign w_free = ~r_m_valid | m_ready;

  // Pick the winning source index from the eligible set.
  always_comb begin
    // NOTE: default assignment first so no path leaves w_winner unassigned
    // (otherwise a latch is inferred).
    w_winner = 1'b0;
    if (w_elig0 && w_elig1) begin
      w_winner = cfg_rr ? ~r_last : 1'b0;
    end else if (w_elig1) begin
      w_winner = 1'b1;
    end
  end

  // Readies depend only on valids, config, m_ready and registered state;
  // nothing from the data path feeds back into them. Both are held low
  // during reset so no frame is taken while the block is being cleared.
  assign s0_ready = ~rst & w_free & w_elig0 & ~w_winner;
  assign s1_ready = ~rst & w_free & w_elig1 &  w_winner;

  assign w_acc0 = s0_valid & s0_ready;
  assign w_acc1 = s1_valid & s1_ready;
  assign w_acc  = w_acc0 | w_acc1;

  // Output register: capture the accepted frame, or empty on drain.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all sequential state so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
      r_grant   <= 1'b0;
      r_last    <= 1'b1;
    end else if (w_acc) begin
      r_m_data  <= w_acc1 ? s1_data : s0_data;
      r_m_valid <= 1'b1;
      r_grant   <= w_acc1;
      r_last    <= w_acc1;
    end else if (r_m_valid && m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

  // Per-source accepted-frame counters; a clear pulse beats an increment.
  always_ff @(posedge clk) begin
    if (rst || cfg_clr_cnt) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_acc0) r_cnt0 <= r_cnt0 + 1'b1;
      if (w_acc1) r_cnt1 <= r_cnt1 + 1'b1;
    end
  end

  assign m_data  = r_m_data;
  assign m_valid = r_m_valid;
  assign grant   = r_grant;
  assign cnt0    = r_cnt0;
  assign cnt1    = r_cnt1;

endmodule

// File: doc/audio_source_arbiter.md
# audio_source_arbiter

Shares the I2S sample FIFO write port between two audio frame sources: source 0 is the hardware sine generator and source 1 is the processor-fed sample stream. It sits between the sources and the `sfifo` write side. Its `m_ready` is driven from `!fifo_full`, and `m_valid` drives the FIFO `i_wr`. The block grants whole 48-bit stereo frames by fixed priority or round-robin, registers the winning frame in a single output stage, and counts accepted frames per source for software status.

## Interface
- `BW`, 48, frame width in bits (left sample in upper half, right sample in lower half; passed through untouched)
- `CW`, 16, width of each per-source frame counter
- `clk`  in  1  system clock; the block's only clock
- `rst`  in  1  reset, synchronous, active-high
- `cfg_src_en`  in  2  per-source enable; bit i enables source i
- `cfg_rr`  in  1  arbitration mode: 0 = fixed priority (source 0 wins), 1 = round-robin
- `cfg_clr_cnt`  in  1  single-cycle pulse that clears both frame counters
- `s0_data`  in  BW  source 0 frame
- `s0_valid`  in  1  source 0 frame available
- `s0_ready`  out  1  source 0 frame accepted this cycle when high together with `s0_valid`
- `s1_data`, `s1_valid`, `s1_ready`  same as source 0, for source 1
- `m_data`  out  BW  registered frame toward the FIFO
- `m_valid`  out  1  output register holds a frame (FIFO write request)
- `m_ready`  in  1  sink can accept (`!fifo_full`)
- `grant`  out  1  index of the source that supplied the frame currently in the output register
- `cnt0`, `cnt1`  out  CW  accepted-frame counters for source 0 and source 1

## Operation
- Eligibility: source i is eligible when `si_valid & cfg_src_en[i]`. A disabled source always sees `si_ready=0`.
- Slot free: `free = !m_valid | m_ready`.
- Winner selection (combinational):
  - One eligible source: it wins.
  - Both eligible, `cfg_rr=0`: source 0 wins.
  - Both eligible, `cfg_rr=1`: the source other than `last` wins.
- `si_ready = free & (winner == i) & eligible_i`. At most one ready is high per cycle.
- Accept (`si_valid & si_ready`):
  - `m_data <= si_data`, `m_valid <= 1`, `grant <= i`, `last <= i`.
  - `cnt_i` increments, wrapping from 2^CW-1 to 0.
- Drain: on `m_valid & m_ready` with no accept in the same cycle, `m_valid <= 0`. `m_data` and `grant` hold their values.
- Accept and drain in the same cycle: the new frame replaces the old one and `m_valid` stays 1. This gives full throughput of one frame per cycle.
- `m_data` stays stable while `m_valid & !m_ready`. Frames are never dropped or duplicated.
- `last` updates only on accept, in both modes. Switching to round-robin mid-stream therefore resumes from the last actual grant.
- `cfg_src_en` or `cfg_rr` changes take effect on the next arbitration. A frame already in the output register is always delivered.
- `cfg_clr_cnt` clears both counters. If it coincides with an accept, the clear wins and the counter reads 0.
- State: output register empty/full (`m_valid`), `last`, two counters. There are no other states.

## Timing
- Reset values: `m_valid=0`, `m_data=0`, `grant=0`, `last=1` (source 0 wins the first round-robin tie), `cnt0=cnt1=0`.
- Reset behaviour:
  - While `rst` is high, `s0_ready=s1_ready=0`.
  - Reset mid-operation discards the held frame on the next edge.
- Latency: a frame accepted at edge N appears on `m_data` with `m_valid=1` after edge N. The FIFO write occurs at the first edge with `m_ready=1` from then on.
- Ready path:
  - `si_ready` is combinational from `si_valid`, `cfg_*`, `m_ready` and registered state.
  - No path runs from `m_data` to any ready.
- Sustained throughput with both sources valid, round-robin, and `m_ready=1`: one frame per cycle, alternating 0,1,0,1.
- Counters update on the edge that accepts the frame.

## Test plan
- Reset and idle:
  - Assert `rst` 2 cycles with both sources valid → readies 0, `m_valid=0`, counters 0.
  - Release → first accept from source 0 (`last=1`) in both modes.
- Round-robin saturation:
  - `cfg_rr=1`, both enabled and always valid, `m_ready=1` for 10 cycles → `grant` sequence 0,1,0,1…
  - `cnt0=cnt1=5`, 10 FIFO writes, no gaps.
- Fixed priority:
  - `cfg_rr=0`, both valid → only source 0 is granted and `s1_ready` stays 0.
  - Drop `s0_valid` → source 1 is accepted next cycle.
- Backpressure:
  - Hold `m_ready=0` for 5 cycles after an accept → `m_valid=1`, `m_data` unchanged, both readies 0.
  - Raise `m_ready` → same-cycle accept of the next frame; the data sequence is intact.
- Enable masking:
  - `cfg_src_en=2'b10` with both valid → only source 1 is served.
  - Set `cfg_src_en=2'b00` while a frame is held → the held frame still drains, then `m_valid=0`.
- Counter wrap and clear:
  - Preload to `cnt0=16'hFFFF` via 65535 accepts; the next accept → `cnt0=0`.
  - `cfg_clr_cnt` coinciding with an accept → counter reads 0.
